// File: rtl/io_pinmux.sv
// rtl/io_pinmux.sv - APB-programmable pad multiplexer with GPIO, input sync and edge interrupts
module io_pinmux #(
    parameter int NPADS       = 38,
    parameter int NFUNC       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [9:0]             PADDR,
    input  logic [31:0]            PWDATA,
    output logic [31:0]            PRDATA,
    output logic                   PREADY,
    input  logic [NFUNC*NPADS-1:0] periph_out,
    input  logic [NFUNC*NPADS-1:0] periph_oe,
    output logic [NFUNC*NPADS-1:0] periph_in,
    input  logic [NPADS-1:0]       pad_in,
    output logic [NPADS-1:0]       pad_out,
    output logic [NPADS-1:0]       pad_oeb,
    output logic                   irq
);
    localparam int FW = $clog2(NFUNC);

    logic [NPADS-1:0] gpio_out_q, gpio_out_d;
    logic [NPADS-1:0] gpio_oe_q, gpio_oe_d;
    logic [NPADS-1:0] ie_q, ie_d;
    logic [NPADS-1:0] pend_q, pend_d;
    logic             lock_q, lock_d;
    logic [FW-1:0]    sel_q [NPADS];
    logic [FW-1:0]    sel_d [NPADS];
    logic [NPADS-1:0] sync_q [SYNC_STAGES];
    logic [NPADS-1:0] d_q;

    logic [NPADS-1:0] s;
    logic [NPADS-1:0] gpio_sel;
    logic [NPADS-1:0] rise;
    logic [63:0]      out_w, oe_w, ie_w, clr_w;
    logic [63:0]      out64, oe64, in64, ie64, pend64;
    logic [7:0]       word;
    logic             sel_hit;
    logic [5:0]       sel_idx;
    logic             wr_en;
    logic             unused_bits;

    assign word    = PADDR[9:2];
    assign sel_hit = (word[7:6] == 2'b01);
    assign sel_idx = word[5:0];
    assign wr_en   = PSEL & PENABLE & PWRITE;
    assign PREADY  = 1'b1;
    assign s       = sync_q[SYNC_STAGES-1];
    assign rise    = s & ~d_q & gpio_sel;
    assign irq     = |(pend_q & ie_q);

    // Function 0 slices of the peripheral buses carry nothing; GPIO is register driven.
    assign unused_bits = ^{PADDR[1:0], periph_out[NPADS-1:0], periph_oe[NPADS-1:0]};

    assign out64  = 64'(gpio_out_q);
    assign oe64   = 64'(gpio_oe_q);
    assign in64   = 64'(s);
    assign ie64   = 64'(ie_q);
    assign pend64 = 64'(pend_q);

    // Register write decode; widening to 64 bits and truncating drops bits of absent pads.
    always_comb begin
        out_w  = out64;
        oe_w   = oe64;
        ie_w   = ie64;
        clr_w  = '0;
        lock_d = lock_q;
        sel_d  = sel_q;
        if (wr_en) begin
            case (word)
                8'h00: out_w[31:0]  = PWDATA;
                8'h01: out_w[63:32] = PWDATA;
                8'h02: if (!lock_q) oe_w[31:0]  = PWDATA;
                8'h03: if (!lock_q) oe_w[63:32] = PWDATA;
                8'h06: ie_w[31:0]   = PWDATA;
                8'h07: ie_w[63:32]  = PWDATA;
                8'h08: clr_w[31:0]  = PWDATA;
                8'h09: clr_w[63:32] = PWDATA;
                8'h0A: if (PWDATA[0]) lock_d = 1'b1;
                default: ;
            endcase
            if (sel_hit && !lock_q) begin
                for (int i = 0; i < NPADS; i++) begin
                    // A selector beyond the last function is stored as GPIO.
                    if (sel_idx == 6'(i))
                        sel_d[i] = (PWDATA < 32'(NFUNC)) ? PWDATA[FW-1:0] : '0;
                end
            end
        end
        gpio_out_d = out_w[NPADS-1:0];
        gpio_oe_d  = oe_w[NPADS-1:0];
        ie_d       = ie_w[NPADS-1:0];
        // A rise on the same edge as a clear leaves the bit pending.
        pend_d     = (pend_q & ~clr_w[NPADS-1:0]) | rise;
    end

    // Control and status registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            gpio_out_q <= '0;
            gpio_oe_q  <= '0;
            ie_q       <= '0;
            pend_q     <= '0;
            lock_q     <= 1'b0;
            for (int i = 0; i < NPADS; i++) sel_q[i] <= '0;
        end else begin
            gpio_out_q <= gpio_out_d;
            gpio_oe_q  <= gpio_oe_d;
            ie_q       <= ie_d;
            pend_q     <= pend_d;
            lock_q     <= lock_d;
            sel_q      <= sel_d;
        end
    end

    // Pad input synchronizer and one-cycle delayed copy for rise detection.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            d_q <= '0;
        end else begin
            sync_q[0] <= pad_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            d_q <= s;
        end
    end

    // Output mux and input demux; any selector not naming a peripheral falls back to GPIO.
    always_comb begin
        gpio_sel  = '1;
        pad_out   = gpio_out_q;
        pad_oeb   = ~gpio_oe_q;
        periph_in = '0;
        for (int i = 0; i < NPADS; i++) begin
            for (int f = 1; f < NFUNC; f++) begin
                if (sel_q[i] == FW'(f)) begin
                    gpio_sel[i]           = 1'b0;
                    pad_out[i]            = periph_out[f*NPADS+i];
                    pad_oeb[i]            = ~periph_oe[f*NPADS+i];
                    periph_in[f*NPADS+i]  = s[i];
                end
            end
        end
    end

    // Combinational read mux; absent pads and unmapped words read zero.
    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            case (word)
                8'h00: PRDATA = out64[31:0];
                8'h01: PRDATA = out64[63:32];
                8'h02: PRDATA = oe64[31:0];
                8'h03: PRDATA = oe64[63:32];
                8'h04: PRDATA = in64[31:0];
                8'h05: PRDATA = in64[63:32];
                8'h06: PRDATA = ie64[31:0];
                8'h07: PRDATA = ie64[63:32];
                8'h08: PRDATA = pend64[31:0];
                8'h09: PRDATA = pend64[63:32];
                8'h0A: PRDATA = {31'b0, lock_q};
                default: begin
                    if (sel_hit) begin
                        for (int i = 0; i < NPADS; i++) begin
                            if (sel_idx == 6'(i)) PRDATA = 32'(sel_q[i]);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_io_pinmux.sv
// tb/tb_io_pinmux.sv - self-checking bench for io_pinmux
module tb_io_pinmux;
    localparam int NP = 38;
    localparam int NF = 4;
    localparam int NW = NP * NF;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          PSEL, PENABLE, PWRITE;
    logic [9:0]    PADDR;
    logic [31:0]   PWDATA, PRDATA;
    logic          PREADY;
    logic [NW-1:0] periph_out, periph_oe, periph_in;
    logic [NP-1:0] pad_in, pad_out, pad_oeb;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    // Reference register state
    logic [NP-1:0] m_out, m_oe, m_ie;
    logic          m_lock;
    int            m_sel [64];

    io_pinmux dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .periph_out(periph_out), .periph_oe(periph_oe), .periph_in(periph_in),
        .pad_in(pad_in), .pad_out(pad_out), .pad_oeb(pad_oeb), .irq(irq)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [9:0] a, input logic [31:0] d);
        @(negedge HCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge HCLK);
        PENABLE = 1'b1;
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [9:0] a, output logic [31:0] d);
        @(negedge HCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        #1 d = PRDATA;
        PSEL = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        HRESETn = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        periph_out = '0; periph_oe = '0; pad_in = '0;
        repeat (2) @(negedge HCLK);
        m_out = '0; m_oe = '0; m_ie = '0; m_lock = 1'b0;
        for (int i = 0; i < 64; i++) m_sel[i] = 0;
        HRESETn = 1'b1;
    endtask

    // Register-level model of a write, in terms of pads rather than bus words.
    task automatic model_write(input logic [9:0] a, input logic [31:0] d);
        int w;
        w = int'(a) / 4;
        for (int b = 0; b < 32; b++) begin
            int p;
            p = (w % 2) * 32 + b;
            if (p < NP) begin
                if (w == 0 || w == 1) m_out[p] = d[b];
                if ((w == 2 || w == 3) && !m_lock) m_oe[p] = d[b];
                if (w == 6 || w == 7) m_ie[p] = d[b];
            end
        end
        if (w == 10 && d[0]) m_lock = 1'b1;
        if (w >= 64 && w < 64 + NP && !m_lock) m_sel[w-64] = int'(d);
    endtask

    function automatic logic [31:0] model_read(input logic [9:0] a);
        int w;
        logic [63:0] v;
        w = int'(a) / 4;
        v = '0;
        if (w == 0 || w == 1) v = 64'(m_out);
        if (w == 2 || w == 3) v = 64'(m_oe);
        if (w == 6 || w == 7) v = 64'(m_ie);
        if (w >= 64) return 32'(m_sel[w-64]);
        return (w % 2 == 1) ? v[63:32] : v[31:0];
    endfunction

    function automatic void model_pads(output logic [NP-1:0] eo, output logic [NP-1:0] eb);
        for (int i = 0; i < NP; i++) begin
            int f;
            f = m_sel[i];
            if (f >= 1 && f < NF) begin
                eo[i] = periph_out[f*NP+i];
                eb[i] = ~periph_oe[f*NP+i];
            end else begin
                eo[i] = m_out[i];
                eb[i] = ~m_oe[i];
            end
        end
    endfunction

    typedef struct {
        logic [31:0] sel;
        logic        gout;
        logic        goe;
        logic [3:0]  pout;
        logic [3:0]  poe;
        logic        exp_out;
        logic        exp_oeb;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [31:0]   rd;
        logic [NP-1:0] eo, eb;
        logic [159:0]  rnd;

        vecs[0] = '{32'd0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0};
        vecs[1] = '{32'd1, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0};
        vecs[2] = '{32'd2, 1'b1, 1'b1, 4'b1011, 4'b1011, 1'b0, 1'b1};
        vecs[3] = '{32'd3, 1'b0, 1'b1, 4'b1000, 4'b0000, 1'b1, 1'b1};
        vecs[4] = '{32'd7, 1'b0, 1'b0, 4'b1110, 4'b1110, 1'b0, 1'b1};
        vecs[5] = '{32'd4, 1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0};

        HRESETn = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        periph_out = '1; periph_oe = '1; pad_in = '1;
        #12;
        chk("reset_pad_oeb", 64'(pad_oeb), 64'h3F_FFFF_FFFF);
        chk("reset_pad_out", 64'(pad_out), 64'h0);
        chk("reset_irq", 64'(irq), 64'h0);
        chk("reset_periph_in", 64'(|periph_in), 64'h0);
        do_reset();
        apb_read(10'h008, rd); chk("reset_oe_read", 64'(rd), 64'h0);
        apb_read(10'h028, rd); chk("reset_lock_read", 64'(rd), 64'h0);

        // Table of mux vectors on pad 3
        for (int v = 0; v < 6; v++) begin
            periph_out = '0; periph_oe = '0;
            for (int f = 0; f < NF; f++) begin
                periph_out[f*NP+3] = vecs[v].pout[f];
                periph_oe[f*NP+3]  = vecs[v].poe[f];
            end
            apb_write(10'h000, {28'b0, vecs[v].gout, 3'b0});
            apb_write(10'h008, {28'b0, vecs[v].goe, 3'b0});
            apb_write(10'h10C, vecs[v].sel);
            #1;
            chk($sformatf("vec%0d_pad_out", v), 64'(pad_out[3]), 64'(vecs[v].exp_out));
            chk($sformatf("vec%0d_pad_oeb", v), 64'(pad_oeb[3]), 64'(vecs[v].exp_oeb));
            if (vecs[v].sel < 32'(NF)) begin
                apb_read(10'h10C, rd);
                chk($sformatf("vec%0d_sel_rd", v), 64'(rd), 64'(vecs[v].sel));
            end
        end

        // Randomized register traffic against the model
        do_reset();
        for (int n = 0; n < 60; n++) begin
            int op, idx;
            logic [9:0]  a;
            logic [31:0] d;
            op = $urandom_range(0, 4);
            d  = $urandom();
            case (op)
                0: a = ($urandom_range(0, 1) == 1) ? 10'h004 : 10'h000;
                1: a = ($urandom_range(0, 1) == 1) ? 10'h00C : 10'h008;
                2: a = ($urandom_range(0, 1) == 1) ? 10'h01C : 10'h018;
                default: begin
                    idx = $urandom_range(0, 45);
                    a = 10'(32'h100 + 4 * idx);
                    d = $urandom_range(0, 5);
                end
            endcase
            apb_write(a, d);
            model_write(a, d);
            rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            periph_out = rnd[NW-1:0];
            rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            periph_oe = rnd[NW-1:0];
            #1;
            model_pads(eo, eb);
            chk($sformatf("rand%0d_pad_out", n), 64'(pad_out), 64'(eo));
            chk($sformatf("rand%0d_pad_oeb", n), 64'(pad_oeb), 64'(eb));
            if (!(a >= 10'h100 && d >= 32'(NF) && (int'(a) - 256) / 4 < NP)) begin
                apb_read(a, rd);
                chk($sformatf("rand%0d_read_%0h", n, a), 64'(rd), 64'(model_read(a)));
            end
        end

        // Mux check on pad 5, function 2
        do_reset();
        periph_out[2*NP+5] = 1'b1;
        periph_oe[2*NP+5]  = 1'b1;
        apb_write(10'h114, 32'd2);
        #1;
        chk("mux_pad_out5", 64'(pad_out[5]), 64'h1);
        chk("mux_pad_oeb5", 64'(pad_oeb[5]), 64'h0);
        @(negedge HCLK);
        pad_in[5] = 1'b1;
        @(posedge HCLK); #1;
        chk("mux_periph_in_1edge", 64'(periph_in[2*NP+5]), 64'h0);
        @(posedge HCLK); #1;
        chk("mux_periph_in_2edge", 64'(periph_in[2*NP+5]), 64'h1);
        chk("mux_periph_in_f1", 64'(periph_in[1*NP+5]), 64'h0);

        // Lock check
        apb_write(10'h028, 32'h1);
        apb_write(10'h114, 32'h0);
        apb_write(10'h008, 32'hFFFF_FFFF);
        apb_read(10'h114, rd); chk("lock_sel5", 64'(rd), 64'h2);
        apb_read(10'h008, rd); chk("lock_oe", 64'(rd), 64'h0);
        apb_read(10'h028, rd); chk("lock_read", 64'(rd), 64'h1);
        apb_write(10'h000, 32'h1);
        apb_read(10'h000, rd); chk("lock_gpio_out", 64'(rd), 64'h1);

        // Interrupt check on pad 33
        apb_write(10'h184, 32'h0);
        apb_write(10'h01C, 32'h2);
        @(negedge HCLK);
        pad_in[33] = 1'b1;
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        chk("irq_before", 64'(irq), 64'h0);
        @(posedge HCLK); #1;
        chk("irq_after_3edges", 64'(irq), 64'h1);
        apb_read(10'h024, rd); chk("pend_hi", 64'(rd), 64'h2);
        apb_write(10'h024, 32'h2);
        #1;
        chk("irq_cleared", 64'(irq), 64'h0);
        apb_read(10'h024, rd); chk("pend_hi_cleared", 64'(rd), 64'h0);

        // Set wins over clear on pad 0
        @(negedge HCLK);
        pad_in[0] = 1'b1;
        @(negedge HCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 10'h020; PWDATA = 32'h1;
        @(negedge HCLK);
        PENABLE = 1'b1;
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        apb_read(10'h020, rd); chk("set_wins_pend0", 64'(rd), 64'h1);

        // Reset in the middle of a transfer aborts the write
        do_reset();
        @(negedge HCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 10'h000; PWDATA = 32'hFF;
        @(negedge HCLK);
        PENABLE = 1'b1;
        #2 HRESETn = 1'b0;
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        HRESETn = 1'b1;
        apb_read(10'h000, rd); chk("abort_gpio_out", 64'(rd), 64'h0);
        chk("abort_pad_out", 64'(pad_out), 64'h0);

        // Out-of-range selectors
        apb_write(10'h1A0, 32'h3);
        apb_read(10'h1A0, rd); chk("sel40_read", 64'(rd), 64'h0);
        periph_out = '1; periph_oe = '1;
        apb_write(10'h10C, 32'h7);
        apb_write(10'h000, 32'h8);
        #1 chk("sel7_pad3_hi", 64'(pad_out[3]), 64'h1);
        apb_write(10'h000, 32'h0);
        #1 chk("sel7_pad3_lo", 64'(pad_out[3]), 64'h0);
        chk("sel7_pad3_oeb", 64'(pad_oeb[3]), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
